// File: rtl/ppu_pkg.sv
// Shared PPU types and constants: data width, op encoding width and the
// arbiter FSM state type.
`ifndef WORD
`define WORD 32
`endif

package ppu_pkg;

  localparam int WORD_W    = `WORD;
  localparam int OP_BITS   = 4;
  localparam int ARB_CNT_W = 16;

  typedef enum logic [1:0] {
    ARB_RUN     = 2'd0,
    ARB_DRAIN   = 2'd1,
    ARB_DRAINED = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ppu_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first valid requester at or above the
// pointer (modulo NUM_REQ), plus the pointer value that follows that grant.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    grant_id_o,
  output logic [ID_W-1:0]    ptr_next_o
);

  logic            found;
  logic [ID_W-1:0] idx;

  always_comb begin
    grant_o    = '0;
    grant_id_o = '0;
    found      = 1'b0;
    idx        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((int'(ptr_i) + i) % NUM_REQ);
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_id_o   = idx;
      end
    end
    ptr_next_o = ID_W'((int'(grant_id_o) + 1) % NUM_REQ);
  end

endmodule

// File: rtl/ppu_arbiter.sv
// Round-robin front end sharing one ppu_top between NUM_REQ requesters, with
// result routing by tag and a flush/drain FSM. Optional PPU_ARB_STATS_EN adds
// per-requester saturating grant counters on grant_cnt_o.
//
// state       | meaning
// ARB_RUN     | arbitrating, one transfer per cycle at most
// ARB_DRAIN   | no new grants, waiting for in-flight ops to retire
// ARB_DRAINED | pipeline empty, flush_done_o high until flush_i drops
module ppu_arbiter
  import ppu_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WORD        = WORD_W,
  parameter int PPU_LATENCY = 2,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ*OP_BITS-1:0] req_op_i,
  input  logic [NUM_REQ*WORD-1:0]    req_operand1_i,
  input  logic [NUM_REQ*WORD-1:0]    req_operand2_i,
  input  logic [NUM_REQ*WORD-1:0]    req_operand3_i,
  output logic [NUM_REQ-1:0]         resp_valid_o,
  output logic [WORD-1:0]            resp_result_o,
  output logic                       ppu_in_valid_o,
  output logic [OP_BITS-1:0]         ppu_op_o,
  output logic [WORD-1:0]            ppu_operand1_o,
  output logic [WORD-1:0]            ppu_operand2_o,
  output logic [WORD-1:0]            ppu_operand3_o,
  input  logic [WORD-1:0]            ppu_result_i,
  input  logic                       ppu_out_valid_i,
  input  logic                       flush_i,
  output logic                       flush_done_o,
  output logic                       err_o
`ifdef PPU_ARB_STATS_EN
  ,
  output logic [NUM_REQ*ARB_CNT_W-1:0] grant_cnt_o
`endif
);

  arb_state_e          state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_next, grant_id;
  logic [NUM_REQ-1:0]  grant;
  logic                xfer, in_flight;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req_i      (req_valid_i),
    .ptr_i      (ptr_q),
    .grant_o    (grant),
    .grant_id_o (grant_id),
    .ptr_next_o (ptr_next)
  );

  assign xfer = |(req_valid_i & req_ready_o);

  always_comb begin
    state_d      = state_q;
    req_ready_o  = '0;
    flush_done_o = 1'b0;
    case (state_q)
      ARB_RUN: begin
        if (flush_i) state_d = ARB_DRAIN;
        else         req_ready_o = grant;
      end
      ARB_DRAIN: begin
        if (!in_flight) state_d = ARB_DRAINED;
      end
      ARB_DRAINED: begin
        flush_done_o = 1'b1;
        if (!flush_i) state_d = ARB_RUN;
      end
      default: state_d = ARB_RUN;
    endcase
  end

  logic [OP_BITS-1:0] sel_op;
  logic [WORD-1:0]    sel_a, sel_b, sel_c;

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    sel_c  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_op = req_op_i[i*OP_BITS +: OP_BITS];
        sel_a  = req_operand1_i[i*WORD +: WORD];
        sel_b  = req_operand2_i[i*WORD +: WORD];
        sel_c  = req_operand3_i[i*WORD +: WORD];
      end
    end
  end

  logic               in_valid_q;
  logic [OP_BITS-1:0] op_q;
  logic [WORD-1:0]    a_q, b_q, c_q;
  logic [ID_W-1:0]    issue_id_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ARB_RUN;
      ptr_q      <= '0;
      in_valid_q <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      issue_id_q <= '0;
    end else begin
      state_q    <= state_d;
      in_valid_q <= xfer;
      if (xfer) begin
        ptr_q      <= ptr_next;
        op_q       <= sel_op;
        a_q        <= sel_a;
        b_q        <= sel_b;
        c_q        <= sel_c;
        issue_id_q <= grant_id;
      end
    end
  end

  assign ppu_in_valid_o = in_valid_q;
  assign ppu_op_o       = op_q;
  assign ppu_operand1_o = a_q;
  assign ppu_operand2_o = b_q;
  assign ppu_operand3_o = c_q;

  // Last tag stage lines up with the cycle ppu_top presents the matching result.
  logic [PPU_LATENCY-1:0] tag_v_q;
  logic [ID_W-1:0]        tag_id_q [PPU_LATENCY];
  logic                   tag_v_out, hit;
  logic [ID_W-1:0]        tag_id_out;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_v_q <= '0;
      for (int k = 0; k < PPU_LATENCY; k++) tag_id_q[k] <= '0;
    end else begin
      tag_v_q[0]  <= in_valid_q;
      tag_id_q[0] <= issue_id_q;
      for (int k = 1; k < PPU_LATENCY; k++) begin
        tag_v_q[k]  <= tag_v_q[k-1];
        tag_id_q[k] <= tag_id_q[k-1];
      end
    end
  end

  assign tag_v_out  = tag_v_q[PPU_LATENCY-1];
  assign tag_id_out = tag_id_q[PPU_LATENCY-1];
  assign in_flight  = in_valid_q | (|tag_v_q);
  assign hit        = tag_v_out & ppu_out_valid_i;

  logic [NUM_REQ-1:0] resp_valid_d, resp_valid_q;
  logic [WORD-1:0]    resp_result_q;
  logic               err_q;

  always_comb begin
    resp_valid_d = '0;
    if (hit) resp_valid_d[tag_id_out] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_valid_q  <= '0;
      resp_result_q <= '0;
      err_q         <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      if (hit) resp_result_q <= ppu_result_i;
      err_q <= err_q | (tag_v_out ^ ppu_out_valid_i);
    end
  end

  assign resp_valid_o  = resp_valid_q;
  assign resp_result_o = resp_result_q;
  assign err_o         = err_q;

`ifdef PPU_ARB_STATS_EN
  logic [ARB_CNT_W-1:0] cnt_q [NUM_REQ];
  logic                 cnt_clr;

  assign cnt_clr = (state_q == ARB_DRAINED) && !flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (cnt_clr)                                    cnt_q[i] <= '0;
        else if (req_valid_i[i] && req_ready_o[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign grant_cnt_o[g*ARB_CNT_W +: ARB_CNT_W] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_ppu_arbiter.sv
// Randomized bench for ppu_arbiter with a behavioural PPU and a reference
// model built from arbitration rules and per-operation response due times.
module tb_ppu_arbiter;
  import ppu_pkg::*;

  localparam int N = 4;
  localparam int W = WORD_W;
  localparam int L = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]         req_valid = '0, req_ready, resp_valid;
  logic [OP_BITS-1:0]   op_a [N];
  logic [W-1:0]         a_a [N], b_a [N], c_a [N];
  logic [N*OP_BITS-1:0] req_op;
  logic [N*W-1:0]       req_a, req_b, req_c;
  logic [W-1:0]         resp_result, ppu_a, ppu_b, ppu_c, ppu_result;
  logic [OP_BITS-1:0]   ppu_op;
  logic                 ppu_in_valid, ppu_out_valid, flush = 1'b0, flush_done, err;
  logic                 inject = 1'b0;
`ifdef PPU_ARB_STATS_EN
  logic [N*ARB_CNT_W-1:0] grant_cnt;
`endif

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_op[g*OP_BITS +: OP_BITS] = op_a[g];
    assign req_a[g*W +: W] = a_a[g];
    assign req_b[g*W +: W] = b_a[g];
    assign req_c[g*W +: W] = c_a[g];
  end

  ppu_arbiter #(.NUM_REQ(N), .PPU_LATENCY(L)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_operand1_i(req_a), .req_operand2_i(req_b), .req_operand3_i(req_c),
    .resp_valid_o(resp_valid), .resp_result_o(resp_result),
    .ppu_in_valid_o(ppu_in_valid), .ppu_op_o(ppu_op),
    .ppu_operand1_o(ppu_a), .ppu_operand2_o(ppu_b), .ppu_operand3_o(ppu_c),
    .ppu_result_i(ppu_result), .ppu_out_valid_i(ppu_out_valid),
    .flush_i(flush), .flush_done_o(flush_done), .err_o(err)
`ifdef PPU_ARB_STATS_EN
    , .grant_cnt_o(grant_cnt)
`endif
  );

  function automatic logic [W-1:0] ppu_fn(input logic [OP_BITS-1:0] op,
                                          input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c);
    return (a + b) ^ c ^ W'(op);
  endfunction

  // Behavioural ppu_top: fixed latency L
  logic         p1_v, p2_v;
  logic [W-1:0] p1_r, p2_r;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_v <= 1'b0; p2_v <= 1'b0; p1_r <= '0; p2_r <= '0;
    end else begin
      p1_v <= ppu_in_valid;
      p1_r <= ppu_fn(ppu_op, ppu_a, ppu_b, ppu_c);
      p2_v <= p1_v;
      p2_r <= p1_r;
    end
  end
  assign ppu_out_valid = p2_v | inject;
  assign ppu_result    = p2_r;

  typedef struct {
    int           due;
    logic [N-1:0] oh;
    logic [W-1:0] res;
  } exp_t;

  exp_t         q[$];
  int           cyc = 0, mptr = 0, mode = 0;
  logic         merr = 1'b0;
  int           checks = 0, passed = 0;
  logic [N-1:0] e_ready, e_oh;
  logic [W-1:0] e_res;
  logic         e_done, e_err;

  // Drive one cycle's inputs, derive this cycle's expected outputs, advance the model.
  task automatic step(input logic [N-1:0] v, input logic fl, input logic inj);
    int   id;
    logic infl;
    exp_t e;
    req_valid = v;
    flush     = fl;
    inject    = inj;
    for (int i = 0; i < N; i++) begin
      op_a[i] = OP_BITS'($urandom);
      a_a[i]  = W'($urandom);
      b_a[i]  = W'($urandom);
      c_a[i]  = W'($urandom);
    end
    #1;
    e_oh  = '0;
    e_res = '0;
    while (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      e_oh  = e.oh;
      e_res = e.res;
    end
    infl    = (q.size() > 0);
    e_done  = (mode == 2);
    e_err   = merr;
    e_ready = '0;
    id      = -1;
    if (mode == 0 && !fl)
      for (int i = 0; i < N; i++)
        if (id < 0 && v[(mptr + i) % N]) id = (mptr + i) % N;
    if (id >= 0) begin
      e_ready[id] = 1'b1;
      e.due = cyc + L + 2;
      e.oh  = e_ready;
      e.res = ppu_fn(op_a[id], a_a[id], b_a[id], c_a[id]);
      q.push_back(e);
      mptr = (id + 1) % N;
    end
    if (inj && !(q.size() > 0 && q[0].due == cyc + 1)) merr = 1'b1;
    case (mode)
      0:       if (fl) mode = 1;
      1:       if (!infl) mode = 2;
      default: if (!fl) mode = 0;
    endcase
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic model_reset();
    q.delete();
    mptr = 0;
    mode = 0;
    merr = 1'b0;
  endtask

  task automatic test_reset();
    logic [N+W+OP_BITS+3*W+4-1:0] outs;
    outs = {req_ready, resp_valid, resp_result, ppu_op, ppu_a, ppu_b, ppu_c, ppu_in_valid, flush_done, err, 1'b0};
    checks++; if (outs !== '0) $display("FAIL reset_outputs got=%h exp=0", outs); else passed++;
    rst_n = 1'b1;
    step(4'b0011, 1'b0, 1'b0); tick();
    step(4'b0011, 1'b0, 1'b0); tick();
    step(4'b0000, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    outs = {req_ready, resp_valid, resp_result, ppu_op, ppu_a, ppu_b, ppu_c, ppu_in_valid, flush_done, err, 1'b0};
    checks++; if (outs !== '0) $display("FAIL midop_reset_outputs got=%h exp=0", outs); else passed++;
    model_reset();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step('0, 1'b0, 1'b0);
      checks++; if (resp_valid !== e_oh) $display("FAIL post_reset_resp got=%b exp=%b", resp_valid, e_oh); else passed++;
      tick();
    end
  endtask

  task automatic test_all_valid();
    int           rc [N];
    logic [N-1:0] exp_g;
    for (int i = 0; i < N; i++) rc[i] = 0;
    for (int i = 0; i < 14; i++) begin
      step(i < 8 ? 4'b1111 : 4'b0000, 1'b0, 1'b0);
      exp_g = (i < 8) ? (N'(1) << (i % N)) : '0;
      checks++; if (req_ready !== exp_g) $display("FAIL rr_grant i=%0d got=%b exp=%b", i, req_ready, exp_g); else passed++;
      checks++; if (resp_valid !== e_oh) $display("FAIL rr_resp cyc=%0d got=%b exp=%b", cyc, resp_valid, e_oh); else passed++;
      if (e_oh != '0) begin
        checks++; if (resp_result !== e_res) $display("FAIL rr_result cyc=%0d got=%h exp=%h", cyc, resp_result, e_res); else passed++;
      end
      for (int r = 0; r < N; r++) if (resp_valid[r]) rc[r]++;
      tick();
    end
    for (int r = 0; r < N; r++) begin
      checks++; if (rc[r] !== 2) $display("FAIL rr_resp_count req=%0d got=%0d exp=2", r, rc[r]); else passed++;
    end
  endtask

  task automatic test_single();
    int run = 0, best = 0;
    for (int i = 0; i < 11; i++) begin
      step(i < 5 ? 4'b0100 : 4'b0000, 1'b0, 1'b0);
      if (i < 5) begin
        checks++; if (req_ready !== 4'b0100) $display("FAIL single_grant i=%0d got=%b exp=0100", i, req_ready); else passed++;
      end
      checks++; if (resp_valid !== e_oh) $display("FAIL single_resp cyc=%0d got=%b exp=%b", cyc, resp_valid, e_oh); else passed++;
      if (e_oh != '0) begin
        checks++; if (resp_result !== e_res) $display("FAIL single_result cyc=%0d got=%h exp=%h", cyc, resp_result, e_res); else passed++;
      end
      run  = (resp_valid == 4'b0100) ? run + 1 : 0;
      best = (run > best) ? run : best;
      tick();
    end
    checks++; if (best !== 5) $display("FAIL single_resp_run got=%0d exp=5", best); else passed++;
  endtask

  task automatic test_flush();
    int   last_resp = -1, done_cyc = -1;
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < 20 && done_cyc < 0; i++) begin
      step(4'b1111, 1'b1, 1'b0);
      checks++; if (req_ready !== '0) $display("FAIL flush_ready cyc=%0d got=%b exp=0", cyc, req_ready); else passed++;
      checks++; if (resp_valid !== e_oh) $display("FAIL flush_resp cyc=%0d got=%b exp=%b", cyc, resp_valid, e_oh); else passed++;
      checks++; if (flush_done !== e_done) $display("FAIL flush_done cyc=%0d got=%b exp=%b", cyc, flush_done, e_done); else passed++;
      if (resp_valid != '0) last_resp = cyc;
      if (flush_done) done_cyc = cyc;
      tick();
    end
    checks++; if (done_cyc < 0) $display("FAIL flush_timeout got=no_done exp=done_within_20");
    else if (done_cyc !== last_resp + 1) $display("FAIL flush_done_time got=%0d exp=%0d", done_cyc, last_resp + 1);
    else passed++;
    step(4'b1111, 1'b0, 1'b0);
    checks++; if ({req_ready, flush_done} !== {4'b0000, 1'b1}) $display("FAIL flush_release got=%b/%b exp=0000/1", req_ready, flush_done); else passed++;
    tick();
    for (int i = 0; i < 7; i++) begin
      step(i == 0 ? 4'b1111 : 4'b0000, 1'b0, 1'b0);
      checks++; if (req_ready !== e_ready || flush_done !== 1'b0)
        $display("FAIL flush_resume cyc=%0d got=%b/%b exp=%b/0", cyc, req_ready, flush_done, e_ready); else passed++;
      checks++; if (resp_valid !== e_oh) $display("FAIL flush_resume_resp cyc=%0d got=%b exp=%b", cyc, resp_valid, e_oh); else passed++;
      tick();
    end
  endtask

  task automatic test_random();
    logic fl = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (i >= 390) fl = 1'b0;
      else if ($urandom_range(0, 14) == 0) fl = ~fl;
      step(i < 390 ? N'($urandom) : '0, fl, 1'b0);
      checks++; if (req_ready !== e_ready) $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, req_ready, e_ready); else passed++;
      checks++; if (resp_valid !== e_oh) $display("FAIL rand_resp cyc=%0d got=%b exp=%b", cyc, resp_valid, e_oh); else passed++;
      if (e_oh != '0) begin
        checks++; if (resp_result !== e_res) $display("FAIL rand_result cyc=%0d got=%h exp=%h", cyc, resp_result, e_res); else passed++;
      end
      checks++; if ({flush_done, err} !== {e_done, e_err}) $display("FAIL rand_done_err cyc=%0d got=%b%b exp=%b%b", cyc, flush_done, err, e_done, e_err); else passed++;
      tick();
    end
  endtask

  task automatic test_error();
    for (int i = 0; i < 8; i++) begin
      step('0, 1'b0, i == 2);
      checks++; if (resp_valid !== '0) $display("FAIL err_no_resp cyc=%0d got=%b exp=0", cyc, resp_valid); else passed++;
      checks++; if (err !== (i > 2)) $display("FAIL err_sticky i=%0d got=%b exp=%b", i, err, i > 2); else passed++;
      checks++; if (err !== e_err) $display("FAIL err_model i=%0d got=%b exp=%b", i, err, e_err); else passed++;
      tick();
    end
    inject = 1'b0;
  endtask

`ifdef PPU_ARB_STATS_EN
  task automatic test_stats();
    rst_n = 1'b0;
    req_valid = '0;
    flush = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    req_valid = 4'b0010;
    repeat (1000) tick();
    checks++; if (grant_cnt[ARB_CNT_W +: ARB_CNT_W] !== 16'd1000)
      $display("FAIL stats_count got=%0d exp=1000", grant_cnt[ARB_CNT_W +: ARB_CNT_W]); else passed++;
    repeat (69000) tick();
    req_valid = '0;
    checks++; if (grant_cnt[ARB_CNT_W +: ARB_CNT_W] !== 16'hFFFF)
      $display("FAIL stats_saturate got=%h exp=ffff", grant_cnt[ARB_CNT_W +: ARB_CNT_W]); else passed++;
    checks++; if ({grant_cnt[3*ARB_CNT_W +: 2*ARB_CNT_W], grant_cnt[0 +: ARB_CNT_W]} !== '0)
      $display("FAIL stats_others got=%h exp=0", grant_cnt); else passed++;
  endtask
`endif

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0; a_a[i] = '0; b_a[i] = '0; c_a[i] = '0;
    end
    repeat (2) @(negedge clk);
    #1;
    test_reset();
    test_all_valid();
    test_single();
    test_flush();
    test_random();
    test_error();
`ifdef PPU_ARB_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
